clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_ctrl.sv | 153 +++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider: registered divided clock, period strobe and phase, shadowed configuration.
// Build option CLKDIV_CTRL_ERR_EN: reject illegal configurations with a cfg_err pulse instead of clamping them.
module clkdiv_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             clk_en,
    output logic [CNT_W-1:0] phase,
    output logic             running
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] L_DIV0 = CNT_W'(7);
    localparam logic [CNT_W-1:0] L_HI0  = CNT_W'(4);

    state_t           r_state;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_sh_div;
    logic [CNT_W-1:0] r_sh_high;
    logic             r_cfg_ready;
    logic             r_cfg_err;
    logic             r_clk_out;
    logic             r_clk_en;
    logic             r_running;

    logic             w_accept;
    logic             w_take;
    logic             w_reject;
    logic             w_wrap;
    logic             w_bypass;
    logic             w_load_shadow;
    logic [CNT_W-1:0] w_new_div;
    logic [CNT_W-1:0] w_new_high;
    logic [CNT_W-1:0] w_nxt_div;
    logic [CNT_W-1:0] w_nxt_high;
    logic [CNT_W-1:0] w_nxt_phase;
    state_t           w_nxt_state;

    // Configuration acceptance: legality check (reject) or clamping (default build)
    always_comb begin
        w_accept = cfg_valid & r_cfg_ready;
`ifdef CLKDIV_CTRL_ERR_EN
        w_new_div  = cfg_div;
        w_new_high = cfg_high;
        if ((cfg_div < L_TWO) || (cfg_high == L_ZERO) || (cfg_high >= cfg_div)) begin
            w_take   = 1'b0;
            w_reject = w_accept;
        end else begin
            w_take   = w_accept;
            w_reject = 1'b0;
        end
`else
        w_new_div = (cfg_div < L_TWO) ? L_TWO : cfg_div;
        if (cfg_high == L_ZERO) begin
            w_new_high = L_ONE;
        end else if (cfg_high >= w_new_div) begin
            w_new_high = w_new_div - L_ONE;
        end else begin
            w_new_high = cfg_high;
        end
        w_take   = w_accept;
        w_reject = 1'b0;
`endif
    end

    // Next state, next phase and next active settings (changed only at a wrap or while idle)
    always_comb begin
        w_wrap        = (r_state != ST_IDLE) && (r_phase == (r_div - L_ONE));
        w_bypass      = w_take && w_wrap;
        w_load_shadow = !r_cfg_ready && (w_wrap || (r_state == ST_IDLE));
        if (w_bypass) begin
            w_nxt_div  = w_new_div;
            w_nxt_high = w_new_high;
        end else if (w_load_shadow) begin
            w_nxt_div  = r_sh_div;
            w_nxt_high = r_sh_high;
        end else begin
            w_nxt_div  = r_div;
            w_nxt_high = r_high;
        end
        case (r_state)
            ST_IDLE:  w_nxt_state = en ? ST_RUN : ST_IDLE;
            ST_RUN:   w_nxt_state = en ? ST_RUN : (w_wrap ? ST_IDLE : ST_DRAIN);
            ST_DRAIN: w_nxt_state = en ? ST_RUN : (w_wrap ? ST_IDLE : ST_DRAIN);
            default:  w_nxt_state = ST_IDLE;
        endcase
        if ((w_nxt_state == ST_IDLE) || (r_state == ST_IDLE) || w_wrap) begin
            w_nxt_phase = L_ZERO;
        end else begin
            w_nxt_phase = r_phase + L_ONE;
        end
    end

    // FSM, settings, shadow and all outputs registered; outputs derive from next-cycle values
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= L_ZERO;
            r_div       <= L_DIV0;
            r_high      <= L_HI0;
            r_sh_div    <= L_ZERO;
            r_sh_high   <= L_ZERO;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
            r_clk_out   <= 1'b0;
            r_clk_en    <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_phase   <= w_nxt_phase;
            r_div     <= w_nxt_div;
            r_high    <= w_nxt_high;
            r_running <= (w_nxt_state != ST_IDLE);
            r_clk_en  <= (w_nxt_state != ST_IDLE) && (w_nxt_phase == L_ZERO);
            r_clk_out <= (w_nxt_state != ST_IDLE) && (w_nxt_phase < w_nxt_high);
            r_cfg_err <= w_reject;
            if (w_take && !w_bypass) begin
                r_sh_div    <= w_new_div;
                r_sh_high   <= w_new_high;
                r_cfg_ready <= 1'b0;
            end else if (w_load_shadow) begin
                r_cfg_ready <= 1'b1;
            end else begin
                r_cfg_ready <= r_cfg_ready;
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign clk_out   = r_clk_out;
    assign clk_en    = r_clk_en;
    assign phase     = r_phase;
    assign running   = r_running;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: table of per-cycle vectors fed through an expected-value queue,
// plus hand-written drain, re-enable, illegal-configuration and mid-period reset sequences.
module tb_clkdiv_ctrl;
    typedef struct {
        logic       en;
        logic       cv;
        logic [3:0] d;
        logic [3:0] h;
        int         ph;
        logic       co;
        logic       ce;
        logic       run;
        logic       rdy;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic [3:0] cfg_div;
    logic [3:0] cfg_high;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       clk_en;
    logic [3:0] phase;
    logic       running;

    int    checks;
    int    failures;
    int    step_no;
    string label;
    vec_t  sb[$];
    vec_t  tbl[$];

    clkdiv_ctrl #(.CNT_W(4)) dut (
        .clk_in    (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .clk_en    (clk_en),
        .phase     (phase),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic en_i, input logic cv_i, input int d_i, input int h_i,
                                input int ph_i, input logic co_i, input logic ce_i,
                                input logic run_i, input logic rdy_i, input logic err_i);
        vec_t v;
        v.en  = en_i;
        v.cv  = cv_i;
        v.d   = d_i[3:0];
        v.h   = h_i[3:0];
        v.ph  = ph_i;
        v.co  = co_i;
        v.ce  = ce_i;
        v.run = run_i;
        v.rdy = rdy_i;
        v.err = err_i;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s#%0d %s got=%0d exp=%0d", label, step_no, name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        label = tag;
        chk("phase", int'(phase), 0);
        chk("clk_out", int'(clk_out), 0);
        chk("clk_en", int'(clk_en), 0);
        chk("running", int'(running), 0);
        chk("cfg_ready", int'(cfg_ready), 1);
        chk("cfg_err", int'(cfg_err), 0);
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the next rising edge.
    task automatic step(input vec_t v);
        vec_t e;
        en        = v.en;
        cfg_valid = v.cv;
        cfg_div   = v.d;
        cfg_high  = v.h;
        sb.push_back(v);
        @(posedge clk);
        #1;
        step_no++;
        e = sb.pop_front();
        chk("phase", int'(phase), e.ph);
        chk("clk_out", int'(clk_out), int'(e.co));
        chk("clk_en", int'(clk_en), int'(e.ce));
        chk("running", int'(running), int'(e.run));
        chk("cfg_ready", int'(cfg_ready), int'(e.rdy));
        chk("cfg_err", int'(cfg_err), int'(e.err));
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 4'd0;
        cfg_high  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle({tag, "_reset"});
        @(negedge clk);
        rst     = 1'b1;
        label   = tag;
        step_no = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        step_no  = 0;
        label    = "init";

        // en, cv, div, high | phase, clk_out, clk_en, running, cfg_ready, cfg_err
        tbl.push_back(mk(1, 0, 0, 0,  0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  3, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 5, 2,  4, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  5, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  6, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  2, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  3, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  4, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 7, 4,  1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  4, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  3, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  4, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  5, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  6, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 10, 5, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  3, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  4, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  5, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  6, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  7, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  8, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 10, 5, 9, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 1, 1, 0));

        // Defaults, shadowed reconfiguration, bypass at wrap, equal reconfiguration
        do_reset("table");
        foreach (tbl[i]) step(tbl[i]);

        // Drop en at phase 2: drain to phase 6, then idle
        do_reset("drain");
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 3, 1, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 4, 0, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 5, 0, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 6, 0, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Re-assert en at phase 5 while draining: no gap, phase continues
        do_reset("rerun");
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 3, 1, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 4, 0, 0, 1, 1, 0));
        step(mk(0, 0, 0, 0, 5, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 6, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0));

        // Illegal configuration cfg_div=1
        do_reset("illegal");
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0));
`ifdef CLKDIV_CTRL_ERR_EN
        step(mk(1, 1, 1, 1, 3, 1, 0, 1, 1, 1));
        step(mk(1, 0, 0, 0, 4, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 5, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 6, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 3, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 4, 0, 0, 1, 1, 0));
`else
        step(mk(1, 1, 1, 1, 3, 1, 0, 1, 0, 0));
        step(mk(1, 0, 0, 0, 4, 0, 0, 1, 0, 0));
        step(mk(1, 0, 0, 0, 5, 0, 0, 1, 0, 0));
        step(mk(1, 0, 0, 0, 6, 0, 0, 1, 0, 0));
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0));
`endif

        // Reset at phase 4 with a pending shadow: outputs clear at once, pending value discarded
        do_reset("midrst");
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 3, 1, 0, 1, 1, 0));
        step(mk(1, 1, 5, 2, 4, 0, 0, 1, 0, 0));
        #2;
        rst       = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check_idle("midrst_async");
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        label   = "after_rst";
        step_no = 0;
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 3, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 4, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 5, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 6, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 3, 1, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 4, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 5, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 6, 0, 0, 1, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
